// File: rtl/borrow_look_ahead_sub_pipe.sv
// borrow_look_ahead_sub_pipe
// Pipelined subtractor producing diff = a - b - bin (modulo 2^WIDTH).
// Each 4-bit nibble is resolved with flattened borrow generate/propagate
// look-ahead in its own stage; the nibble borrow-out is registered into the
// next stage. The whole pipeline advances as one unit under a valid/ready
// handshake, so bubbles travel through rather than being compressed.
// WIDTH must be a multiple of 4 and at least 4.
module borrow_look_ahead_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // One pipeline stage per nibble; the last stage drives the outputs.
  localparam int NSTG = WIDTH / 4;

  // One nibble of a - b - x0 with all borrows flattened to two logic levels.
  // Returns {nibble borrow-out, 4-bit difference}.
  function automatic logic [4:0] nibble_sub(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       x0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] brw;
    logic       bo;
    g      = ~x & y;       // borrow generated: 0 - 1
    p      = ~(x ^ y);     // borrow propagated: equal bits
    brw[0] = x0;
    brw[1] = g[0] | (p[0] & x0);
    brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & x0);
    brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & x0);
    bo     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & x0);
    return {bo, x ^ y ^ brw};
  endfunction

  // The pipeline moves only when the output slot is free or being drained;
  // in_ready therefore depends on registered state and out_ready alone.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = 4 * k;

    // Stage inputs: operands still to be resolved (nibble k and above),
    // borrow into nibble k, and the already resolved lower diff nibbles.
    logic                valid_in;
    logic                x_in;
    logic [WIDTH-1:LO]   a_in;
    logic [WIDTH-1:LO]   b_in;
    logic [4:0]          nib;
    logic [LO+3:0]       d_new;

    // Stage registers.
    logic                v_q;
    logic                brw_q;
    logic [LO+3:0]       d_q;

    if (k == 0) begin : g_first
      assign valid_in = in_valid;
      assign x_in     = bin;
      assign a_in     = a;
      assign b_in     = b;
      assign d_new    = nib[3:0];
    end else begin : g_next
      assign valid_in = g_stg[k-1].v_q;
      assign x_in     = g_stg[k-1].brw_q;
      assign a_in     = g_stg[k-1].g_fwd.a_q;
      assign b_in     = g_stg[k-1].g_fwd.b_q;
      assign d_new    = {nib[3:0], g_stg[k-1].d_q};
    end

    assign nib = nibble_sub(a_in[LO+3:LO], b_in[LO+3:LO], x_in);

    // Capture this nibble's result and borrow; hold everything on a stall,
    // and leave data untouched when a bubble passes through.
    always_ff @(posedge clk) begin
      // NOTE: data registers are cleared on reset too, so the outputs read
      // zero after reset rather than whatever the flops powered up with.
      if (rst) begin
        // NOTE: state uses non-blocking assignment so every stage samples the
        // previous stage's old value on the same edge.
        v_q   <= 1'b0;
        brw_q <= 1'b0;
        d_q   <= '0;
      end else if (advance) begin
        v_q <= valid_in;
        if (valid_in) begin
          brw_q <= nib[4];
          d_q   <= d_new;
        end
      end
    end

    if (k == NSTG - 1) begin : g_last
      // Flags come from the complete diff and the operand sign bits that
      // travelled with this operation.
      logic ovf_n;
      logic zero_n;
      logic ovf_q;
      logic zero_q;
      assign ovf_n  = (a_in[WIDTH-1] ^ b_in[WIDTH-1]) & (d_new[WIDTH-1] ^ a_in[WIDTH-1]);
      assign zero_n = (d_new == '0);

      // Register the flags alongside diff so they change together.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance && valid_in) begin
          ovf_q  <= ovf_n;
          zero_q <= zero_n;
        end
      end
    end else begin : g_fwd
      // Only the still-unresolved upper operand nibbles move forward.
      logic [WIDTH-1:LO+4] a_q;
      logic [WIDTH-1:LO+4] b_q;

      // Carry the upper operand nibbles to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && valid_in) begin
          a_q <= a_in[WIDTH-1:LO+4];
          b_q <= b_in[WIDTH-1:LO+4];
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].v_q;
  assign diff      = g_stg[NSTG-1].d_q;
  assign bout      = g_stg[NSTG-1].brw_q;
  assign ovf       = g_stg[NSTG-1].g_last.ovf_q;
  assign zero      = g_stg[NSTG-1].g_last.zero_q;

endmodule

// File: tb/tb_borrow_look_ahead_sub_pipe.sv
// Self-checking bench for borrow_look_ahead_sub_pipe (WIDTH=8).
// Expected results are pushed to a queue when an input transfer happens and
// popped when an output transfer happens. Inputs are driven on the falling
// edge and outputs sampled shortly after it.
module tb_borrow_look_ahead_sub_pipe;

  localparam int WIDTH = 8;

  typedef logic [WIDTH+2:0] res_t;  // {bout, ovf, zero, diff}

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  int   checks;
  int   errors;
  res_t sb[$];
  res_t last_out;
  bit   in_fire;
  bit   out_fire;

  borrow_look_ahead_sub_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: wide subtraction, borrow is the bit above the MSB.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic bi);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] d;
    logic             v;
    t = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    d = t[WIDTH-1:0];
    v = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    return {t[WIDTH], v, (d == '0), d};
  endfunction

  // One clock cycle: observe both handshakes, score the output, enqueue the
  // accepted input, then move to the next falling edge.
  task automatic cycle();
    res_t exp_r;
    res_t got_r;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      got_r    = {bout, ovf, zero, diff};
      last_out = got_r;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", got_r);
      end else begin
        exp_r = sb.pop_front();
        if (got_r !== exp_r) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", got_r, exp_r);
        end
      end
    end
    if (in_fire) sb.push_back(model(a, b, bin));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    bin       = bi;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = in_fire;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: got accepted=0 expected accepted=1");
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, bout, ovf, zero, diff} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, bout, ovf, zero, diff});
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    in_valid  = 1'b1;
    a         = 8'h5A;
    b         = 8'h3C;
    bin       = 1'b0;
    out_ready = 1'b1;
    cycle();
    checks++;
    if (!in_fire) begin
      errors++;
      $display("FAIL basic_accept: got 0 expected 1");
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got out_valid=%b expected 0", out_valid);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got out_valid=%b expected 1", out_valid);
    end
    checks++;
    if ({bout, ovf, zero, diff} !== {3'b000, 8'h1E}) begin
      errors++;
      $display("FAIL basic_value: got %h expected %h", {bout, ovf, zero, diff}, {3'b000, 8'h1E});
    end
    drain();
  endtask

  task automatic test_boundaries();
    do_op(8'h00, 8'h01, 1'b0); drain();
    checks++;
    if (last_out !== {3'b100, 8'hFF}) begin
      errors++;
      $display("FAIL underflow: got %h expected %h", last_out, {3'b100, 8'hFF});
    end
    do_op(8'h00, 8'hFF, 1'b1); drain();
    checks++;
    if (last_out !== {3'b101, 8'h00}) begin
      errors++;
      $display("FAIL underflow_zero: got %h expected %h", last_out, {3'b101, 8'h00});
    end
    do_op(8'h80, 8'h01, 1'b0); drain();
    checks++;
    if (last_out !== {3'b010, 8'h7F}) begin
      errors++;
      $display("FAIL signed_overflow: got %h expected %h", last_out, {3'b010, 8'h7F});
    end
    do_op(8'h10, 8'h0F, 1'b1); drain();
    checks++;
    if (last_out !== {3'b001, 8'h00}) begin
      errors++;
      $display("FAIL cross_nibble: got %h expected %h", last_out, {3'b001, 8'h00});
    end
    do_op(8'hA5, 8'hA5, 1'b1); drain();
    checks++;
    if (last_out !== {3'b100, 8'hFF}) begin
      errors++;
      $display("FAIL equal_with_bin: got %h expected %h", last_out, {3'b100, 8'hFF});
    end
  endtask

  task automatic test_back_to_back();
    int   idx;
    int   phase;
    int   stall_n;
    res_t snap;
    idx       = 0;
    phase     = 0;
    stall_n   = 0;
    snap      = '0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && (idx < 6 || sb.size() > 0); cyc++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        a   = WIDTH'(idx * 8'h11);
        b   = WIDTH'(idx);
        bin = idx[0];
      end
      if (phase == 0 && out_valid) begin
        phase = 1;
        snap  = {bout, ovf, zero, diff};
      end
      if (phase == 1) begin
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({out_valid, bout, ovf, zero, diff} !== {1'b1, snap}) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", {out_valid, bout, ovf, zero, diff},
                   {1'b1, snap});
        end
        stall_n++;
      end else begin
        out_ready = 1'b1;
        if (phase == 2) begin
          #1;
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL throughput_bubble: got out_valid=%b expected 1", out_valid);
          end
        end
      end
      cycle();
      if (in_fire) idx++;
      if (phase == 1 && stall_n == 3) phase = 2;
    end
    checks++;
    if (idx != 6 || sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_done: got idx=%0d pending=%0d expected idx=6 pending=0",
               idx, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h11; b = 8'h22; bin = 1'b0;
    cycle();
    a = 8'h33; b = 8'h44; bin = 1'b1;
    cycle();
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({out_valid, bout, ovf, zero, diff} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {out_valid, bout, ovf, zero, diff});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stale: got out_valid=%b expected 0", out_valid);
      end
      cycle();
    end
    do_op(8'h03, 8'h05, 1'b0); drain();
    checks++;
    if (last_out !== {3'b100, 8'hFE}) begin
      errors++;
      $display("FAIL reset_mid_new_op: got %h expected %h", last_out, {3'b100, 8'hFE});
    end
  endtask

  task automatic test_random();
    int acc;
    acc = 0;
    for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (in_fire) acc++;
    end
    checks++;
    if (acc != 10000) begin
      errors++;
      $display("FAIL random_count: got %0d expected 10000", acc);
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_out = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
